fetch_unit: RTL and testbench

//  Program counter and fetch controller directly upstream of the instruction memory.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_next_mux.sv | 36 +++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: opcode/filler constants, data widths
// and the fetch controller state encoding.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0]         OPC_HALT = 4'hF;
  localparam logic [INSTR_W-1:0] IR_RESET = 16'hF000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next program-counter select with fixed priority: redirect target, then
// hold, then increment. The PC is AW bits wide, so the increment wraps
// modulo 2**AW and the redirect target keeps only its low AW bits.
//
// Ports:
//   pc_i         current PC
//   br_taken_i   redirect request (already qualified by the caller)
//   br_target_i  full-width redirect address; only the low AW bits are used
//   hold_i       keep the current PC
//   pc_next_o    selected next PC
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic [AW-1:0]     pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              hold_i,
  output logic [AW-1:0]     pc_next_o
);

  // Upper target bits fall outside the memory and are intentionally dropped.
  logic unused_target_hi;
  assign unused_target_hi = ^br_target_i[ADDR_W-1:AW];

  always_comb begin
    pc_next_o = pc_i + AW'(1);
    if (br_taken_i) begin
      pc_next_o = br_target_i[AW-1:0];
    end else if (hold_i) begin
      pc_next_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch controller in front of a combinational
// instruction memory. Holds ready low while memory boots, then fetches one
// word per cycle into the instruction register, honouring stalls, redirects
// and the HALT opcode.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   stall        decoder cannot accept a new IR this cycle
//   br_taken     redirect request
//   br_target    redirect word address (low log2(IM_DEPTH) bits used)
//   instruction  word returned by instruction memory for addr
//   addr         word address to instruction memory (= PC, zero-extended)
//   ready        memory enable (high only while running)
//   ir           registered instruction
//   ir_pc        address ir was fetched from
//   ir_valid     ir holds a live instruction
//   halted       HALT executed; frozen until reset
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IM_DEPTH    = 32,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  addr,
  output logic               ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  output logic               halted
);

  localparam int unsigned AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam int unsigned CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  fetch_state_e       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;

  logic running;
  logic br_eff;
  logic capture;
  logic halt_det;
  logic pc_hold;

  assign running  = (state_q == ST_RUN);
  assign br_eff   = running && br_taken;
  assign capture  = running && !br_taken && !stall;
  assign halt_det = capture && (instruction[INSTR_W-1:INSTR_W-4] == OPC_HALT);
  // PC only moves on a redirect or a normal non-HALT capture.
  assign pc_hold  = !capture || halt_det;

  pc_next_mux #(
    .AW (AW)
  ) u_pc_next_mux (
    .pc_i        (pc_q),
    .br_taken_i  (br_eff),
    .br_target_i (br_target),
    .hold_i      (pc_hold),
    .pc_next_o   (pc_d)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BOOT_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (br_taken) begin
          ir_valid_d = 1'b0;
        end else if (!stall) begin
          ir_d       = instruction;
          ir_pc_d    = ADDR_W'(pc_q);
          ir_valid_d = 1'b1;
          if (halt_det) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      pc_q       <= AW'(RESET_PC);
      ir_q       <= IR_RESET;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign addr     = ADDR_W'(pc_q);
  assign ready    = running;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] instruction;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        halted;

  logic [15:0] mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .IM_DEPTH    (32),
    .BOOT_CYCLES (2),
    .RESET_PC    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instruction (instruction),
    .addr        (addr),
    .ready       (ready),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; returns the filler while disabled.
  always_comb begin
    instruction = ready ? mem[addr[4:0]] : 16'hF000;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] addr;
    logic        ready;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        v;
    logic        h;
  } vec_t;

  vec_t tbl [17];

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ea, input logic er,
                           input logic [15:0] eir, input logic [15:0] eirpc,
                           input logic ev, input logic eh);
    cmp({tag, ".addr"},     addr,            ea);
    cmp({tag, ".ready"},    16'(ready),      16'(er));
    cmp({tag, ".ir"},       ir,              eir);
    cmp({tag, ".ir_pc"},    ir_pc,           eirpc);
    cmp({tag, ".ir_valid"}, 16'(ir_valid),   16'(ev));
    cmp({tag, ".halted"},   16'(halted),     16'(eh));
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst       = r;
    stall     = s;
    br_taken  = b;
    br_target = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);

    //          rst   stall br    tgt       addr      rdy   ir        ir_pc     v     h
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hF000, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 16'h1001, 16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 16'h1002, 16'h0002, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1003, 16'h0003, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0005, 1'b1, 16'h1004, 16'h0004, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'h1005, 16'h0005, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0007, 1'b1, 16'h1006, 16'h0006, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 16'h0012, 16'h0012, 1'b1, 16'h1006, 16'h0006, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0013, 1'b1, 16'h1012, 16'h0012, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 16'hFFE3, 16'h0003, 1'b1, 16'h1012, 16'h0012, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h1003, 16'h0003, 1'b1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].tgt);
      check_all($sformatf("v%0d", i), tbl[i].addr, tbl[i].ready, tbl[i].ir,
                tbl[i].ir_pc, tbl[i].v, tbl[i].h);
    end

    // Wrap-around into a HALT word, then redirects/stalls must be ignored.
    mem[31] = 16'h1234;
    mem[0]  = 16'hF005;
    step(1'b0, 1'b0, 1'b1, 16'h001E);
    check_all("wrap.br",   16'h001E, 1'b1, 16'h1003, 16'h0003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("wrap.30",   16'h001F, 1'b1, 16'h101E, 16'h001E, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("wrap.31",   16'h0000, 1'b1, 16'h1234, 16'h001F, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("halt.cap",  16'h0000, 1'b0, 16'hF005, 16'h0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0005);
    check_all("halt.br",   16'h0000, 1'b0, 16'hF005, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0009);
    check_all("halt.hold", 16'h0000, 1'b0, 16'hF005, 16'h0000, 1'b0, 1'b1);

    // Reset out of HALT; redirect and stall are ignored during boot.
    mem[0] = 16'h1000;
    step(1'b1, 1'b1, 1'b1, 16'h0005);
    check_all("rst.halt",  16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0005);
    check_all("boot.1",    16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h0005);
    check_all("boot.2",    16'h0000, 1'b1, 16'hF000, 16'h0000, 1'b0, 1'b0);

    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      check_all($sformatf("run%0d", k), 16'(k), 1'b1, 16'h1000 + 16'(k - 1),
                16'(k - 1), 1'b1, 1'b0);
    end

    // Reset mid-run at PC=9.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    check_all("rst.mid",   16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("reboot.1",  16'h0000, 1'b0, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("reboot.2",  16'h0000, 1'b1, 16'hF000, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_all("reboot.3",  16'h0001, 1'b1, 16'h1000, 16'h0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
